// File: rtl/vga_plot_sink_if.sv
// vga_plot_sink_if: pixel-plot write port plus VGA pin bundle
interface vga_plot_sink_if;
  logic       plot;
  logic [2:0] color;
  logic [8:0] X;
  logic [7:0] Y;
  logic       busy;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  modport master (
    output plot, color, X, Y,
    input  busy, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
  );
  modport slave (
    input  plot, color, X, Y,
    output busy, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: 320x240x3 framebuffer written by plot strobes, scanned out as 2x-scaled VGA
module vga_plot_sink #(
  parameter int         H_ACTIVE       = 640,
  parameter int         H_FP           = 16,
  parameter int         H_SYNC         = 96,
  parameter int         H_BP           = 48,
  parameter int         V_ACTIVE       = 480,
  parameter int         V_FP           = 10,
  parameter int         V_SYNC         = 2,
  parameter int         V_BP           = 33,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [2:0] CLEAR_COLOR    = 3'b000
) (
  input logic           clock,
  input logic           reset,
  vga_plot_sink_if.slave bus
);
  localparam logic [9:0]  H_VIS   = 10'(H_ACTIVE);
  localparam logic [9:0]  HS_ON   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_OFF  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_VIS   = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [16:0] FB_LAST = 17'd76799;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state_q, state_d;
  logic        pix_en_q;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [16:0] clr_addr_q, clr_addr_d;
  logic [2:0]  rd_q;
  logic [2:0]  fb [76800];
  logic        h_wrap, clr_last, in_range, we;
  logic [16:0] rd_addr, plot_addr, wr_addr;
  logic [2:0]  wr_data;

  always_comb begin
    h_wrap    = hcnt_q == H_LAST;
    hcnt_d    = pix_en_q ? (h_wrap ? '0 : hcnt_q + 10'd1) : hcnt_q;
    vcnt_d    = (pix_en_q && h_wrap) ? (vcnt_q == V_LAST ? '0 : vcnt_q + 10'd1) : vcnt_q;
    hs_d      = pix_en_q ? !(hcnt_q >= HS_ON && hcnt_q < HS_OFF) : hs_q;
    vs_d      = pix_en_q ? !(vcnt_q >= VS_ON && vcnt_q < VS_OFF) : vs_q;
    blank_n_d = pix_en_q ? (hcnt_q < H_VIS && vcnt_q < V_VIS) : blank_n_q;
  end

  // each stored pixel covers a 2x2 block of screen pixels
  assign rd_addr   = ({8'd0, vcnt_q[9:1]} << 8) + ({8'd0, vcnt_q[9:1]} << 6) + {8'd0, hcnt_q[9:1]};
  assign plot_addr = ({9'd0, bus.Y} << 8) + ({9'd0, bus.Y} << 6) + {8'd0, bus.X};

  always_comb begin
    clr_last   = clr_addr_q == FB_LAST;
    in_range   = bus.X < 9'd320 && bus.Y < 8'd240;
    state_d    = (state_q == CLEAR && clr_last) ? RUN : state_q;
    clr_addr_d = (state_q == CLEAR && !clr_last) ? clr_addr_q + 17'd1 : '0;
    we         = state_q == CLEAR || (bus.plot && in_range);
    wr_addr    = state_q == CLEAR ? clr_addr_q : plot_addr;
    wr_data    = state_q == CLEAR ? CLEAR_COLOR : bus.color;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_addr_q <= '0;
      pix_en_q   <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pix_en_q   <= !pix_en_q;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_n_q  <= blank_n_d;
    end
  end

  // read-before-write: a same-address read this cycle returns the old colour
  always_ff @(posedge clock) begin
    if (we) fb[wr_addr] <= wr_data;
    if (pix_en_q) rd_q <= fb[rd_addr];
  end

  assign bus.busy        = state_q == CLEAR;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLANK_N = blank_n_q;
  assign bus.VGA_R       = {8{rd_q[2] & blank_n_q}};
  assign bus.VGA_G       = {8{rd_q[1] & blank_n_q}};
  assign bus.VGA_B       = {8{rd_q[0] & blank_n_q}};
endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: directed checks of clear sweep, plotting, VGA timing and reset
module tb_vga_plot_sink;
  localparam int HA = 32, HF = 2, HSY = 4, HB = 2, HT = HA + HF + HSY + HB;
  localparam int VA = 14, VF = 1, VSY = 2, VB = 1, VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  vga_plot_sink_if bus();

  vga_plot_sink #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .CLEAR_ON_RESET(1'b1), .CLEAR_COLOR(3'b000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // clock edges since reset release; outputs for tick n are valid after edge 2n+2
  always @(posedge clock or posedge reset) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B};
  endfunction

  task automatic wait_pos(input int h, input int v);
    int n = v * HT + h;
    while (2 * n + 2 <= cyc) n += FRAME;
    while (cyc != 2 * n + 2) @(negedge clock);
  endtask

  task automatic px(input string tag, input int h, input int v, input logic [31:0] exp);
    wait_pos(h, v);
    check(tag, rgb(), exp);
  endtask

  task automatic plot_px(input int x, input int y, input int c);
    bus.plot  = 1'b1;
    bus.X     = 9'(x);
    bus.Y     = 8'(y);
    bus.color = 3'(c);
    @(negedge clock);
  endtask

  // write lands in the same cycle the scan reads that address
  task automatic plot_sync(input int h, input int v, input int x, input int y, input int c);
    int n = v * HT + h;
    while (2 * n + 1 <= cyc) n += FRAME;
    while (cyc != 2 * n + 1) @(negedge clock);
    plot_px(x, y, c);
    bus.plot = 1'b0;
    check("same_cycle_old", rgb(), 32'h000000);
  endtask

  initial begin
    int lows = 0, blanks = 0, f0 = -1, f1 = -1;
    logic prev = 1'b1;
    bus.plot = 1'b0; bus.X = '0; bus.Y = '0; bus.color = '0;
    repeat (3) @(negedge clock);
    check("rst_hs", bus.VGA_HS, 1);
    check("rst_vs", bus.VGA_VS, 1);
    check("rst_blank", bus.VGA_BLANK_N, 0);
    check("rst_rgb", rgb(), 0);
    check("rst_busy", bus.busy, 1);
    reset = 1'b0;
    while (cyc != 70000) @(negedge clock);
    plot_px(2, 2, 7);
    bus.plot = 1'b0;
    while (cyc != 76799) @(negedge clock);
    check("busy_last", bus.busy, 1);
    @(negedge clock);
    check("busy_done", bus.busy, 0);
    plot_px(5, 3, 5);
    plot_px(17, 1, 7);
    plot_px(15, 2, 7);
    plot_px(320, 0, 7);
    plot_px(0, 240, 7);
    bus.plot = 1'b0;
    px("nb_above", 10, 5, 32'h000000);
    px("nb_left", 9, 6, 32'h000000);
    px("px_10_6", 10, 6, 32'hFF00FF);
    px("px_11_6", 11, 6, 32'hFF00FF);
    px("nb_right", 12, 6, 32'h000000);
    px("px_10_7", 10, 7, 32'hFF00FF);
    px("px_11_7", 11, 7, 32'hFF00FF);
    px("nb_below", 10, 8, 32'h000000);
    px("oob_x_0_0", 0, 0, 32'h000000);
    px("oob_x_alias", 0, 2, 32'h000000);
    px("rgb_in_blank", 34, 2, 32'h000000);
    px("busy_plot_drop", 4, 4, 32'h000000);
    wait_pos(0, 8);
    for (int i = 0; i < 2 * HT; i++) begin
      if (prev && !bus.VGA_HS) begin
        if (f0 < 0) f0 = cyc; else f1 = cyc;
      end
      prev = bus.VGA_HS;
      lows += int'(!bus.VGA_HS);
      blanks += int'(bus.VGA_BLANK_N);
      @(negedge clock);
      @(negedge clock);
    end
    check("hs_low_ticks", lows, 2 * HSY);
    check("blank_n_ticks", blanks, 2 * HA);
    check("hs_period", f1 - f0, 2 * HT);
    wait_pos(31, 13); check("blank_last_vis", bus.VGA_BLANK_N, 1);
    wait_pos(32, 13); check("blank_h_end", bus.VGA_BLANK_N, 0);
    wait_pos(0, 14);  check("blank_v_end", bus.VGA_BLANK_N, 0);
    check("vs_before", bus.VGA_VS, 1);
    wait_pos(0, 15);  check("vs_start", bus.VGA_VS, 0);
    wait_pos(39, 16); check("vs_end_line", bus.VGA_VS, 0);
    wait_pos(0, 17);  check("vs_after", bus.VGA_VS, 1);
    plot_sync(21, 11, 10, 5, 2);
    px("new_next_frame_a", 20, 10, 32'h00FF00);
    px("new_next_frame_b", 21, 11, 32'h00FF00);
    px("pre_rst_px", 30, 4, 32'hFFFFFF);
    check("pre_rst_blank", bus.VGA_BLANK_N, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_blank", bus.VGA_BLANK_N, 0);
    check("arst_rgb", rgb(), 0);
    check("arst_hs", bus.VGA_HS, 1);
    check("arst_vs", bus.VGA_VS, 1);
    check("arst_busy", bus.busy, 1);
    @(negedge clock);
    reset = 1'b0;
    wait_pos(0, 0);
    check("restart_blank", bus.VGA_BLANK_N, 1);
    wait_pos(33, 0); check("restart_hs_hi", bus.VGA_HS, 1);
    wait_pos(34, 0); check("restart_hs_lo", bus.VGA_HS, 0);
    check("restart_busy", bus.busy, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
